rename_alloc_ctrl: RTL and testbench
====================================

# rename_alloc_ctrl

Sequencer and arbiter in front of the physical-register free list in the rename stage. Grants one physical-register allocation per cycle to the rename stage and passes ROB-commit frees straight through. Holds up to `N_CKPT` branch checkpoints of the free-list read pointer. On a branch mispredict it runs a restore sequence that rewinds the free list and flushes all younger checkpoints.

## Interface
- `N_CKPT`, 4: number of branch checkpoints; power of two.
- `PTR_W`, 8: free-list pointer width; pointers wrap modulo `DEPTH`.
- `DEPTH`, 128: free-list depth.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `alloc_req` in 1: rename requests one physical register.
- `alloc_gnt` out 1: allocation granted this cycle.
- `alloc_tag` out 7: granted physical-register tag; equals `fl_ptr[6:0]`.
- `free_valid` in 1: ROB commit frees one register.
- `br_dispatch` in 1: branch at rename requests a checkpoint.
- `br_gnt` out 1: checkpoint granted.
- `br_tag` out log2(N_CKPT): id of the granted checkpoint.
- `ckpt_full` out 1: no free checkpoint.
- `res_valid` in 1: branch resolution presented.
- `res_ready` out 1: resolution accepted this cycle.
- `res_tag` in log2(N_CKPT): checkpoint id being resolved.
- `res_mispredict` in 1: resolution is a mispredict.
- `stall` out 1: rename must hold.
- `fl_write_en` out 1: to free list.
- `fl_read_en` out 1: to free list.
- `fl_spec` out 1: to free list.
- `fl_mispredict` out 1: to free list.
- `fl_re_ptr` out PTR_W: to free list.
- `fl_ptr` in PTR_W: from free list.
- `fl_empty` in 1: from free list.

## Operation
- FSM states: RUN, RESTORE, SETTLE. Reset state is RUN.
  - RUN: accepted mispredict → RESTORE.
  - RESTORE → SETTLE unconditionally.
  - SETTLE → RUN unconditionally.
- `alloc_gnt` = `alloc_req` & RUN & !`fl_empty` & !(`res_valid`&`res_mispredict`).
- `fl_read_en` = `alloc_gnt`.
- `fl_spec` = (state != RUN).
- `fl_write_en` = `free_valid`, in every state, never gated.
- `stall` = (state != RUN) | `fl_empty` | (`br_dispatch` & `ckpt_full`).
- Checkpoint queue: circular, with `head`/`tail` indices plus a wrap bit and a per-entry valid bit.
  - `ckpt_full` = (count == N_CKPT), where count = `tail` − `head` including the wrap bit.
- `br_gnt` = `br_dispatch` & RUN & !`ckpt_full` & !(`res_valid`&`res_mispredict`).
  - On grant: entry[`tail`] = {valid=1, ptr=(`fl_ptr` + `alloc_gnt`) mod DEPTH}, `br_tag`=`tail`, then `tail`++.
  - A same-cycle allocation is older than the branch, so it is included in the checkpoint.
- `res_ready` = RUN. Resolutions presented outside RUN are held off by the requester.
- Correct resolve (`res_mispredict`=0): clear valid[`res_tag`].
- Mispredict on tag t:
  - Latch entry[t].ptr into the restore register.
  - Clear valid for t and every younger entry (t up to `tail`−1, circular).
  - `tail` := t, go RESTORE.
- Head reclaim: while count > 0 and valid[`head`]=0, `head`++ (one entry per cycle).
- Resolve on an entry whose valid bit is clear: ignored, no state change.
- RESTORE: drive `fl_mispredict`=1 and `fl_re_ptr` = restore register; `fl_read_en`=0.
- Outside RESTORE: `fl_mispredict`=0 and `fl_re_ptr`=0.

## Timing
- `alloc_tag`, `alloc_gnt` and `br_gnt` are combinational from the same-cycle inputs and `fl_ptr`/`fl_empty`.
- The free list advances `fl_ptr` at the following edge.
- Mispredict accepted in cycle T:
  - T+1: RESTORE.
  - T+2: SETTLE; `fl_ptr` now shows the restored value.
  - T+3: RUN; the first post-recovery grant returns the restored tag.
- Simultaneous events:
  - Mispredict beats same-cycle alloc and branch dispatch; neither is granted.
  - Mispredict and free in the same cycle: free still issued.
  - Correct resolve and `br_gnt` in the same cycle: both take effect.
- `ckpt_full` is registered-state based. A checkpoint reclaimed at edge E makes room from cycle E+1.
- Reset output values:
  - `alloc_gnt`=0, `br_gnt`=0, `ckpt_full`=0, `res_ready`=1.
  - `stall` = `fl_empty`.
  - All `fl_*` outputs 0.
  - `head`=`tail`=0, all valid bits 0.
- Reset asserted during RESTORE or SETTLE aborts recovery immediately and returns to RUN.

## Test plan
- After reset with `fl_ptr`=0: `alloc_req` held for 3 cycles → `alloc_gnt`=1 each cycle, tags 0,1,2, `fl_read_en` pulses 3 times.
- `fl_empty`=1 with `alloc_req`=1 → `alloc_gnt`=0 and `stall`=1. A `free_valid` pulse in the same cycle still gives `fl_write_en`=1.
- `br_dispatch` with `alloc_gnt` in the same cycle at `fl_ptr`=10 → `br_tag`=0, checkpoint 0 stores 11. Four branches → `ckpt_full`=1 and the 5th `br_gnt`=0.
- Checkpoints 0..3 stored (11,14,20,25); mispredict on tag 1 →
  - T+1: `fl_mispredict`=1, `fl_re_ptr`=14.
  - Tags 1..3 invalidated, `tail`=1.
  - T+3: RUN with `alloc_tag`=14.
- Correct resolve of tag 0 → `head` advances to 1 the next cycle, `ckpt_full` drops. Resolve of an already-freed tag → no change.
- Mispredict accepted, `reset` asserted in RESTORE → `fl_mispredict`=0 immediately, state RUN, checkpoint queue empty.

Source files
------------

// File: rtl/rename_alloc_ctrl.sv
// Rename-stage allocation sequencer: grants free-list pops, forwards commit frees,
// and keeps a circular queue of branch checkpoints used to rewind the free list.
module rename_alloc_ctrl #(
  parameter int N_CKPT = 4,
  parameter int PTR_W  = 8,
  parameter int DEPTH  = 128,
  localparam int IDX_W = $clog2(N_CKPT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [6:0]       alloc_tag,
  input  logic             free_valid,
  input  logic             br_dispatch,
  output logic             br_gnt,
  output logic [IDX_W-1:0] br_tag,
  output logic             ckpt_full,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [IDX_W-1:0] res_tag,
  input  logic             res_mispredict,
  output logic             stall,
  output logic             fl_write_en,
  output logic             fl_read_en,
  output logic             fl_spec,
  output logic             fl_mispredict,
  output logic [PTR_W-1:0] fl_re_ptr,
  input  logic [PTR_W-1:0] fl_ptr,
  input  logic             fl_empty
);

  typedef enum logic [1:0] {RUN, RESTORE, SETTLE} state_t;

  state_t            state;
  logic [IDX_W:0]    head, tail, count;
  logic [N_CKPT-1:0] valid, flush_mask;
  logic [PTR_W-1:0]  ckpt_ptr [N_CKPT];
  logic [PTR_W-1:0]  restore_ptr, ckpt_val;
  logic [PTR_W:0]    ptr_sum;
  logic [IDX_W-1:0]  misp_offset, entry_offset;
  logic              in_run, mispredict_req, res_hit, mispredict_ok, resolve_ok, reclaim;

  assign in_run         = (state == RUN);
  assign mispredict_req = res_valid & res_mispredict;
  assign count          = tail - head;
  assign ckpt_full      = (count == (IDX_W+1)'(N_CKPT));

  assign alloc_gnt   = alloc_req & in_run & ~fl_empty & ~mispredict_req;
  assign alloc_tag   = fl_ptr[6:0];
  assign fl_read_en  = alloc_gnt;
  assign fl_write_en = free_valid;
  assign fl_spec     = ~in_run;
  assign stall       = ~in_run | fl_empty | (br_dispatch & ckpt_full);
  assign br_gnt      = br_dispatch & in_run & ~ckpt_full & ~mispredict_req;
  assign br_tag      = tail[IDX_W-1:0];
  assign res_ready   = in_run;

  assign fl_mispredict = (state == RESTORE);
  assign fl_re_ptr     = fl_mispredict ? restore_ptr : '0;

  // A same-cycle allocation is older than the branch, so the checkpoint skips past it.
  assign ptr_sum  = {1'b0, fl_ptr} + {{PTR_W{1'b0}}, alloc_gnt};
  assign ckpt_val = (ptr_sum >= (PTR_W+1)'(DEPTH)) ? PTR_W'(ptr_sum - (PTR_W+1)'(DEPTH))
                                                   : ptr_sum[PTR_W-1:0];

  assign res_hit       = res_valid & in_run & valid[res_tag];
  assign mispredict_ok = res_hit & res_mispredict;
  assign resolve_ok    = res_hit & ~res_mispredict;
  assign reclaim       = (count != '0) & ~valid[head[IDX_W-1:0]];
  assign misp_offset   = res_tag - head[IDX_W-1:0];

  // Entries at or beyond the mispredicted one (in age order from head) are younger.
  always_comb begin
    flush_mask   = '0;
    entry_offset = '0;
    for (int i = 0; i < N_CKPT; i++) begin
      entry_offset  = IDX_W'(i) - head[IDX_W-1:0];
      flush_mask[i] = (entry_offset >= misp_offset);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      head        <= '0;
      tail        <= '0;
      valid       <= '0;
      restore_ptr <= '0;
      for (int i = 0; i < N_CKPT; i++) ckpt_ptr[i] <= '0;
    end else begin
      if (reclaim) head <= head + (IDX_W+1)'(1);
      case (state)
        RUN: begin
          if (mispredict_ok) begin
            state       <= RESTORE;
            restore_ptr <= ckpt_ptr[res_tag];
            tail        <= head + {1'b0, misp_offset};
            valid       <= valid & ~flush_mask;
          end else begin
            if (resolve_ok) valid[res_tag] <= 1'b0;
            if (br_gnt) begin
              valid[tail[IDX_W-1:0]]    <= 1'b1;
              ckpt_ptr[tail[IDX_W-1:0]] <= ckpt_val;
              tail                      <= tail + (IDX_W+1)'(1);
            end
          end
        end
        RESTORE: state <= SETTLE;
        SETTLE:  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// Directed bench for rename_alloc_ctrl: the bench plays the free list by driving fl_ptr
// per cycle, then checks grants, checkpoint bookkeeping and the restore sequence.
module tb_rename_alloc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_req, free_valid, br_dispatch, res_valid, res_mispredict, fl_empty;
  logic [1:0] res_tag;
  logic [7:0] fl_ptr;
  logic       alloc_gnt, br_gnt, ckpt_full, res_ready, stall;
  logic       fl_write_en, fl_read_en, fl_spec, fl_mispredict;
  logic [6:0] alloc_tag;
  logic [1:0] br_tag;
  logic [7:0] fl_re_ptr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string name;
    int ar, fv, bd, rv, rt, rm, ptr, emp;
    int ag, tag, bg, bt, full, rr, st, we, re, sp, fm, rep;
  } vec_t;

  vec_t vecs[$];

  rename_alloc_ctrl dut (
    .clk(clk), .reset(reset),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .free_valid(free_valid),
    .br_dispatch(br_dispatch), .br_gnt(br_gnt), .br_tag(br_tag), .ckpt_full(ckpt_full),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_mispredict(res_mispredict), .stall(stall),
    .fl_write_en(fl_write_en), .fl_read_en(fl_read_en), .fl_spec(fl_spec),
    .fl_mispredict(fl_mispredict), .fl_re_ptr(fl_re_ptr),
    .fl_ptr(fl_ptr), .fl_empty(fl_empty)
  );

  always #5 clk = ~clk;

  function automatic logic [25:0] actualOutputs();
    return {alloc_gnt, alloc_tag, br_gnt, br_tag, ckpt_full, res_ready, stall,
            fl_write_en, fl_read_en, fl_spec, fl_mispredict, fl_re_ptr};
  endfunction

  task automatic applyStimulus(input vec_t v);
    alloc_req      = v.ar[0];
    free_valid     = v.fv[0];
    br_dispatch    = v.bd[0];
    res_valid      = v.rv[0];
    res_tag        = 2'(v.rt);
    res_mispredict = v.rm[0];
    fl_ptr         = 8'(v.ptr);
    fl_empty       = v.emp[0];
  endtask

  task automatic checkOutput(input vec_t v);
    logic [25:0] expv, act;
    expv = {v.ag[0], 7'(v.tag), v.bg[0], 2'(v.bt), v.full[0], v.rr[0], v.st[0],
            v.we[0], v.re[0], v.sp[0], v.fm[0], 8'(v.rep)};
    act  = actualOutputs();
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", v.name, act, expv);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, act, expv);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // name, ar fv bd rv rt rm ptr emp | ag tag bg bt full rr st we re sp fm rep
    vecs.push_back(vec_t'{"alloc0",        1,0,0,0,0,0,  0,0, 1,  0,0,0,0,1,0,0,1,0,0, 0});
    vecs.push_back(vec_t'{"alloc1",        1,0,0,0,0,0,  1,0, 1,  1,0,0,0,1,0,0,1,0,0, 0});
    vecs.push_back(vec_t'{"alloc2",        1,0,0,0,0,0,  2,0, 1,  2,0,0,0,1,0,0,1,0,0, 0});
    vecs.push_back(vec_t'{"empty_free",    1,1,0,0,0,0,  3,1, 0,  3,0,0,0,1,1,1,0,0,0, 0});
    vecs.push_back(vec_t'{"br0_alloc",     1,0,1,0,0,0, 10,0, 1, 10,1,0,0,1,0,0,1,0,0, 0});
    vecs.push_back(vec_t'{"br1",           0,0,1,0,0,0, 14,0, 0, 14,1,1,0,1,0,0,0,0,0, 0});
    vecs.push_back(vec_t'{"br2_alloc",     1,0,1,0,0,0, 19,0, 1, 19,1,2,0,1,0,0,1,0,0, 0});
    vecs.push_back(vec_t'{"br3_alloc",     1,0,1,0,0,0, 24,0, 1, 24,1,3,0,1,0,0,1,0,0, 0});
    vecs.push_back(vec_t'{"br4_full",      0,0,1,0,0,0, 25,0, 0, 25,0,0,1,1,1,0,0,0,0, 0});
    vecs.push_back(vec_t'{"misp_t1",       1,1,1,1,1,1, 25,0, 0, 25,0,0,1,1,1,1,0,0,0, 0});
    vecs.push_back(vec_t'{"restore_t1",    1,0,0,0,0,0, 25,0, 0, 25,0,1,0,0,1,0,0,1,1,14});
    vecs.push_back(vec_t'{"settle_t1",     1,0,0,0,0,0, 14,0, 0, 14,0,1,0,0,1,0,0,1,0, 0});
    vecs.push_back(vec_t'{"run_tag14",     1,0,0,0,0,0, 14,0, 1, 14,0,1,0,1,0,0,1,0,0, 0});
    vecs.push_back(vec_t'{"br_t1",         0,0,1,0,0,0, 15,0, 0, 15,1,1,0,1,0,0,0,0,0, 0});
    vecs.push_back(vec_t'{"br_t2",         0,0,1,0,0,0, 16,0, 0, 16,1,2,0,1,0,0,0,0,0, 0});
    vecs.push_back(vec_t'{"br_t3",         0,0,1,0,0,0, 17,0, 0, 17,1,3,0,1,0,0,0,0,0, 0});
    vecs.push_back(vec_t'{"resolve_t0",    0,0,0,1,0,0, 18,0, 0, 18,0,0,1,1,0,0,0,0,0, 0});
    vecs.push_back(vec_t'{"full_holds",    0,0,1,0,0,0, 18,0, 0, 18,0,0,1,1,1,0,0,0,0, 0});
    vecs.push_back(vec_t'{"res_and_br",    0,0,1,1,1,0, 18,0, 0, 18,1,0,0,1,0,0,0,0,0, 0});
    vecs.push_back(vec_t'{"misp_stale_t1", 0,0,0,1,1,1, 18,0, 0, 18,0,1,1,1,0,0,0,0,0, 0});
    vecs.push_back(vec_t'{"stale_ignored", 0,0,0,0,0,0, 18,0, 0, 18,0,1,0,1,0,0,0,0,0, 0});
    vecs.push_back(vec_t'{"misp_t3",       0,0,0,1,3,1, 18,0, 0, 18,0,1,0,1,0,0,0,0,0, 0});

    reset = 1'b1;
    alloc_req = 0; free_valid = 0; br_dispatch = 0; res_valid = 0;
    res_tag = '0; res_mispredict = 0; fl_ptr = '0; fl_empty = 1'b1;
    #3;
    checkValue("reset_outputs", int'(actualOutputs()),
               int'({1'b0, 7'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}));
    fl_empty = 1'b0;
    #1;
    checkValue("reset_stall_follows_empty", int'(stall), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i]);
      @(posedge clk);
      #1;
    end

    // Now in RESTORE for tag 3; reset must abort recovery at once.
    res_valid = 0; res_mispredict = 0; res_tag = '0;
    @(negedge clk);
    checkValue("restore_t3_mispredict", int'(fl_mispredict), 1);
    checkValue("restore_t3_ptr", int'(fl_re_ptr), 17);
    reset = 1'b1;
    #1;
    checkValue("reset_abort_mispredict", int'(fl_mispredict), 0);
    checkValue("reset_abort_re_ptr", int'(fl_re_ptr), 0);
    checkValue("reset_abort_run", int'({fl_spec, res_ready}), 1);
    checkValue("reset_abort_tail", int'(br_tag), 0);
    #2;
    reset = 1'b0;

    // Checkpoint across the DEPTH wrap: ptr 127 plus a same-cycle alloc stores 0.
    @(posedge clk);
    #1;
    alloc_req = 1; br_dispatch = 1; fl_ptr = 8'd127;
    @(negedge clk);
    checkValue("wrap_alloc_tag", int'(alloc_tag), 127);
    checkValue("wrap_br_grant", int'({alloc_gnt, br_gnt, br_tag}), 12);
    @(posedge clk);
    #1;
    alloc_req = 0; br_dispatch = 0; fl_ptr = 8'd0;
    res_valid = 1; res_tag = 2'd0; res_mispredict = 1;
    @(negedge clk);
    checkValue("queue_after_reset", int'({ckpt_full, br_tag}), 1);
    @(posedge clk);
    #1;
    res_valid = 0; res_mispredict = 0;
    @(negedge clk);
    checkValue("wrap_restore", int'({fl_mispredict, fl_re_ptr}), 256);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkValue("back_to_run", int'({fl_spec, res_ready, stall}), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
